soc_button_ctrl: RTL and testbench
==================================

# soc_button_ctrl

Debounced, interrupt-capable Avalon-MM slave for the board push-buttons. It replaces the bare input PIO and sequences each button through synchronisation, debounce and edge capture. It exposes level, raw, mask and edge-capture registers to the Nios II, and raises a level IRQ for unmasked captured edges. It sits on the SoC's peripheral bus beside the other PIO slaves.

## Interface
- `WIDTH`, 4: number of button inputs.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); minimum 2.
- `INVERT`, 1: 1 = buttons active-low on the board; the block inverts them so that pressed reads as 1.
- `EDGE_TYPE`, 0: 0 = capture press (0→1 after inversion), 1 = capture release, 2 = capture both.

Ports:
- `clk` input 1: single clock; all logic in this domain.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 2: register word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write is `chipselect & ~write_n`.
- `writedata` input 32: write data.
- `in_port` input WIDTH: raw, asynchronous button pins.
- `readdata` output 32: registered read data.
- `irq` output 1: level interrupt, registered.

## Operation
- Register map:
  - Address 0 DATA (RO): debounced level.
  - Address 1 RAW (RO): synchronised, undebounced level after inversion.
  - Address 2 MASK (RW): interrupt enable per bit.
  - Address 3 EDGE (RW1C): edge capture; writing 1 clears that bit.
  - All registers use bits [WIDTH-1:0]. Upper bits read 0, and writes to them are ignored. Writes to DATA and RAW are ignored.
- Per-bit pipeline: 2-FF synchroniser → optional inversion → debouncer → edge detector → EDGE register.
- Debouncer, two states per bit:
  - STABLE: the counter holds 0 while the synchronised value equals the debounced value. A mismatch moves the bit to SETTLING with the counter at 1.
  - SETTLING: the counter increments each cycle while the mismatch persists. If the input returns to the debounced value, the bit goes back to STABLE and the counter returns to 0. When the counter reaches DEBOUNCE_CYCLES with the mismatch still present, the debounced value toggles, the counter clears, and the bit returns to STABLE.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- Edge detect: compare the debounced value with its one-cycle-delayed copy and select edges per EDGE_TYPE. A detected edge sets the EDGE bit in the following cycle.
- EDGE set and a W1C clear of the same bit in the same cycle: set wins, so the bit stays 1.
- `irq` is the registered value of |(EDGE & MASK). Changing MASK affects `irq` one cycle later.
- Reset values:
  - Synchroniser flops, debounced state, delayed copy, counters, MASK, EDGE, `readdata` and `irq` are all 0.
  - With INVERT=1, a released button therefore reads 0 immediately, and no spurious edge is generated after reset.
- Reset asserted mid-debounce discards the count; settling restarts from 0 after reset is released.

## Timing
- `readdata` is updated every cycle from `address` (no read strobe), with 1-cycle latency, so data is valid the cycle after the address is presented.
- Reads have no side effects.
- Write takes effect at the clock edge where the write strobe is sampled; the register value is visible on a read issued the next cycle.
- Pin to RAW: 2 cycles of synchroniser plus 1 cycle of `readdata` register.
- Pin change to DATA update: 2 + DEBOUNCE_CYCLES cycles.
- EDGE bit sets 1 cycle after the DATA update.
- `irq` asserts 1 cycle after the EDGE bit sets (MASK set) and deasserts 1 cycle after the clearing write.
- Glitches shorter than DEBOUNCE_CYCLES never change DATA or EDGE.

## Structure
- Package `soc_button_pkg` holds:
  - Register address constants: ADDR_DATA=0, ADDR_RAW=1, ADDR_MASK=2, ADDR_EDGE=3.
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module `soc_button_debounce` contains one bit's synchroniser, inversion and debounce FSM/counter. It is instantiated WIDTH times in a generate loop.
- The top level holds the edge detect, MASK/EDGE registers, read mux and `irq`.

## Test plan
Run with DEBOUNCE_CYCLES=8, INVERT=1, EDGE_TYPE=0, WIDTH=4.
- **Reset:** hold `reset` high with `in_port`=4'hF. Required: `readdata`=0 and `irq`=0. After release, DATA reads 0 and EDGE reads 0 with no edge ever set.
- **Clean press:** drive `in_port[0]` low at cycle 0. Required: RAW bit0 reads 1 from cycle 3, DATA bit0 is 1 at cycle 10, EDGE bit0 is 1 at cycle 11, and with MASK=1 `irq`=1 at cycle 12.
- **Glitch rejection:** pulse `in_port[1]` low for 7 cycles, then return it high. Required: DATA and EDGE stay 0 and the counter returns to 0. Then hold low for 8+ cycles; the DATA bit sets.
- **W1C and collision:** with EDGE=4'b0011, write 32'h1 to address 3. Required: EDGE reads 4'b0010. Then issue a clear of bit1 on the same cycle a new bit1 edge is detected; EDGE bit1 stays 1.
- **Mask gating:** with EDGE bit2 set and MASK=0, required `irq`=0. Write MASK=4'h4; required `irq`=1 exactly one cycle later. Write MASK=0; `irq` drops one cycle later.
- **Reset mid-settle:** assert `reset` at cycle 5 of a settle. Required: all outputs 0 and the counter cleared. After release with the pin still held, DATA sets at 2+8 cycles after the release edge.

Source files
------------

// File: rtl/soc_button_pkg.sv
// Shared constants and types for the push-button controller.
// Register word addresses, edge-select encodings and debounce states.
package soc_button_pkg;

  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RAW  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_e;

endpackage

// File: rtl/soc_button_debounce.sv
// One button: 2-FF synchroniser with polarity fix, then a stable/settling
// debouncer that accepts a new level after DEBOUNCE_CYCLES mismatching cycles.
module soc_button_debounce
  import soc_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic raw_o,
  output logic level_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             mismatch_c;

  // Polarity is fixed ahead of the flops so reset (all 0) means "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= pin_i ^ INVERT;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign mismatch_c = (sync2_q != level_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (mismatch_c) begin
          state_d = DB_SETTLING;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_SETTLING: begin
        if (!mismatch_c) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // This cycle completes DEBOUNCE_CYCLES of mismatch: accept it.
          state_d = DB_STABLE;
          cnt_d   = '0;
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign raw_o   = sync2_q;
  assign level_o = level_q;

endmodule

// File: rtl/soc_button_ctrl.sv
// Avalon-MM button slave: per-bit debouncers, edge capture with W1C clear,
// interrupt mask, registered read mux and registered level IRQ.
module soc_button_ctrl
  import soc_button_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b1,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [WIDTH-1:0] raw_sync, level_db;
  logic [WIDTH-1:0] level_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_det_c;
  logic [31:0]      readdata_d;
  logic             irq_d;
  logic             wr_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .pin_i  (in_port[i]),
      .raw_o  (raw_sync[i]),
      .level_o(level_db[i])
    );
  end

  if (WIDTH < 32) begin : g_wdata_unused
    logic wdata_hi_unused;
    assign wdata_hi_unused = ^writedata[31:WIDTH];
  end

  assign wr_c = chipselect & ~write_n;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det_c = ~level_db & level_dly_q;
      EDGE_ANY:  edge_det_c = level_db ^ level_dly_q;
      default:   edge_det_c = level_db & ~level_dly_q;
    endcase
  end

  // A new edge overrides a same-cycle W1C clear of that bit.
  always_comb begin
    mask_d     = mask_q;
    edge_d     = edge_q;
    readdata_d = '0;
    irq_d      = |(edge_q & mask_q);
    if (wr_c && (address == ADDR_MASK)) mask_d = writedata[WIDTH-1:0];
    if (wr_c && (address == ADDR_EDGE)) edge_d = edge_q & ~writedata[WIDTH-1:0];
    edge_d = edge_d | edge_det_c;
    case (address)
      ADDR_DATA: readdata_d = 32'(level_db);
      ADDR_RAW:  readdata_d = 32'(raw_sync);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_dly_q <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      level_dly_q <= level_db;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      readdata    <= readdata_d;
      irq         <= irq_d;
    end
  end

endmodule

// File: tb/tb_soc_button_ctrl.sv
// Self-checking bench for soc_button_ctrl: register-access vector table,
// directed multi-cycle sequences and random traffic against a reference model.
module tb_soc_button_ctrl;
  import soc_button_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned DEB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [W-1:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  soc_button_ctrl #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .INVERT(1'b1), .EDGE_TYPE(EDGE_RISE)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: pressed = ~pin seen two clocks late; a level is accepted
  // once the synchronised value has disagreed with it for DEB cycles in a row.
  typedef struct packed {
    logic [3:0][7:0] run;
    logic [3:0]      s1, s2, deb, dly, mask, edg;
    logic [31:0]     rd;
    logic            irq;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, logic [1:0] a, logic cs,
                                        logic wn, logic [31:0] wd, logic [3:0] pin);
    model_t n = c;
    logic   wr = cs && !wn;
    case (a)
      2'd0:    n.rd = {28'd0, c.deb};
      2'd1:    n.rd = {28'd0, c.s2};
      2'd2:    n.rd = {28'd0, c.mask};
      default: n.rd = {28'd0, c.edg};
    endcase
    n.irq = |(c.edg & c.mask);
    if (wr && a == 2'd2) n.mask = wd[3:0];
    if (wr && a == 2'd3) n.edg = c.edg & ~wd[3:0];
    n.edg = n.edg | (c.deb & ~c.dly);
    for (int b = 0; b < 4; b++) begin
      if (c.s2[b] != c.deb[b]) begin
        n.run[b] = c.run[b] + 8'd1;
        if (n.run[b] == 8'(DEB)) begin
          n.deb[b] = ~c.deb[b];
          n.run[b] = 8'd0;
        end
      end else begin
        n.run[b] = 8'd0;
      end
    end
    n.dly = c.deb;
    n.s2  = c.s1;
    n.s1  = ~pin;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, address, chipselect, write_n, writedata, in_port);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_readdata", readdata, m.rd);
      check("model_irq", {31'd0, irq}, {31'd0, m.irq});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  typedef struct packed {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    vecs[0]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFF5, 32'h0, 1'b0};
    vecs[1]  = '{2'd2, 1'b1, 1'b1, 32'h0,         32'h5, 1'b0};
    vecs[2]  = '{2'd0, 1'b1, 1'b0, 32'hF,         32'h0, 1'b0};
    vecs[3]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[4]  = '{2'd1, 1'b1, 1'b0, 32'hF,         32'h0, 1'b0};
    vecs[5]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[6]  = '{2'd3, 1'b1, 1'b0, 32'hF,         32'h0, 1'b0};
    vecs[7]  = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[8]  = '{2'd2, 1'b1, 1'b0, 32'h0,         32'h5, 1'b0};
    vecs[9]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[10] = '{2'd2, 1'b0, 1'b0, 32'hF,         32'h0, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};

    // Reset with all buttons released
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    repeat (20) tick();
    rd(2'd0, v); check("post_reset_data", v, 32'h0);
    rd(2'd1, v); check("post_reset_raw", v, 32'h0);
    rd(2'd3, v); check("post_reset_edge", v, 32'h0);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      address = vecs[i].addr; chipselect = vecs[i].cs;
      write_n = vecs[i].wn;   writedata  = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Clean press of bit0 with MASK bit0 enabled
    wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    address = 2'd1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2)  check("press_raw_c2", readdata, 32'h0);
      if (c == 3) begin check("press_raw_c3", readdata, 32'h1); address = 2'd0; end
      if (c == 10) check("press_data_c10", readdata, 32'h0);
      if (c == 11) begin
        check("press_data_c11", readdata, 32'h1);
        check("press_irq_c11", {31'd0, irq}, 32'h0);
        address = 2'd3;
      end
      if (c == 12) begin
        check("press_edge_c12", readdata, 32'h1);
        check("press_irq_c12", {31'd0, irq}, 32'h1);
      end
    end

    // Glitch of DEB-1 cycles on bit1 is rejected, then a full hold is accepted
    in_port[1] = 1'b0;
    repeat (DEB - 1) tick();
    in_port[1] = 1'b1;
    repeat (12) tick();
    rd(2'd0, v); check("glitch_data", v, 32'h1);
    rd(2'd3, v); check("glitch_edge", v, 32'h1);
    in_port[1] = 1'b0;
    address = 2'd0;
    repeat (10) tick();
    check("hold_data_c10", readdata, 32'h1);
    tick();
    check("hold_data_c11", readdata, 32'h3);
    repeat (2) tick();
    rd(2'd3, v); check("edge_both", v, 32'h3);

    // W1C of bit0, then clear of bit1 colliding with a new bit1 edge
    wr(2'd3, 32'h1);
    rd(2'd3, v); check("w1c_bit0", v, 32'h2);
    in_port[1] = 1'b1;
    repeat (12) tick();
    wr(2'd3, 32'h2);
    rd(2'd3, v); check("w1c_bit1", v, 32'h0);
    in_port[1] = 1'b0;
    repeat (10) tick();
    wr(2'd3, 32'h2);
    rd(2'd3, v); check("collision_set_wins", v, 32'h2);

    // Mask gating on bit2
    wr(2'd2, 32'h0);
    in_port[2] = 1'b0;
    repeat (14) tick();
    rd(2'd3, v); check("mask_edge", v, 32'h6);
    check("mask0_irq", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h4);
    check("mask_set_irq_c0", {31'd0, irq}, 32'h0);
    tick();
    check("mask_set_irq_c1", {31'd0, irq}, 32'h1);
    wr(2'd2, 32'h0);
    check("mask_clr_irq_c0", {31'd0, irq}, 32'h1);
    tick();
    check("mask_clr_irq_c1", {31'd0, irq}, 32'h0);

    // Reset in the middle of a settle on bit3
    wr(2'd2, 32'hF);
    in_port[3] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    repeat (3) tick();
    check("midreset_hold_readdata", readdata, 32'h0);
    reset = 1'b0;
    address = 2'd0;
    repeat (10) tick();
    check("rel_data_c10", readdata, 32'h0);
    tick();
    check("rel_data_c11", readdata, 32'hF);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(15) == 0) in_port[b] = ~in_port[b];
      address = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(1)); write_n = 1'b1;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
